// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: ALU pass-through, single in-flight load/store, registered writeback beat
//
// Optional feature macro: MEM_STAGE_MISALIGN_CHECK_EN
//   defined   : loads/stores with opr_res[1:0] != 0 are suppressed and
//               produce a beat flagged out_misaligned (no memory request)
//   undefined : low address bits are dropped (force-aligned) and
//               out_misaligned is tied to 0

package ex_stage_pkg;

  // Execute-stage result record (73 bits, rd in the MSBs)
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] opr_b;
    logic [31:0] opr_res;
    logic        rf_en;
    logic        dm_en;
    logic [1:0]  wb_sel;
  } ex_stage_out_t;

endpackage

module mem_stage
  import ex_stage_pkg::*;
(
  input  logic          clk,
  input  logic          arst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  ex_stage_out_t ex_in,
  output logic          dm_req,
  output logic          dm_we,
  output logic [31:0]   dm_addr,
  output logic [31:0]   dm_wdata,
  input  logic          dm_gnt,
  input  logic          dm_rvalid,
  input  logic [31:0]   dm_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4:0]    out_rd,
  output logic [31:0]   out_data,
  output logic          out_rf_en,
  output logic          out_misaligned
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Latched memory operation (only meaningful in REQ/RESP)
  logic [4:0]  r_op_rd;
  logic [31:0] r_op_b;
  logic [31:0] r_op_res;
  logic        r_op_rf_en;
  logic        r_op_store;

  // Writeback output register
  logic        r_out_valid;
  logic [4:0]  r_out_rd;
  logic [31:0] r_out_data;
  logic        r_out_rf_en;
  logic        r_out_mis;

  // Input classification
  logic        w_is_store;
  logic        w_is_load;
  logic        w_is_mem;
  logic        w_misaligned;
  logic        w_in_ready;
  logic        w_accept;

  // Next-state / datapath controls from the FSM
  logic        w_latch_op;
  logic        w_load_out;
  logic [4:0]  w_ld_rd;
  logic [31:0] w_ld_data;
  logic        w_ld_rf_en;
  logic        w_ld_mis;
  logic        w_dm_req;
  logic        w_dm_we;
  logic [31:0] w_dm_addr;
  logic [31:0] w_dm_wdata;

  // A store wins over the load encoding when dm_en is set
  assign w_is_store = ex_in.dm_en;
  assign w_is_load  = !ex_in.dm_en && (ex_in.wb_sel == 2'b01);
  assign w_is_mem   = w_is_store || w_is_load;

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  assign w_misaligned = w_is_mem && (ex_in.opr_res[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  // Accept only in IDLE with an empty or draining output register, so a
  // completing memory op always finds the output register free
  assign w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  // Next-state logic, memory request drive and output-register load selection
  always_comb begin
    w_state_nxt = r_state;
    w_latch_op  = 1'b0;
    w_load_out  = 1'b0;
    w_ld_rd     = r_op_rd;
    w_ld_data   = r_op_res;
    w_ld_rf_en  = r_op_rf_en;
    w_ld_mis    = 1'b0;
    w_dm_req    = 1'b0;
    w_dm_we     = 1'b0;
    w_dm_addr   = 32'd0;
    w_dm_wdata  = 32'd0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_mem && !w_misaligned) begin
            w_latch_op  = 1'b1;
            w_state_nxt = ST_REQ;
          end else begin
            // ALU result, or a suppressed misaligned access
            w_load_out = 1'b1;
            w_ld_rd    = ex_in.rd;
            w_ld_data  = ex_in.opr_res;
            w_ld_rf_en = ex_in.rf_en && !w_misaligned;
            w_ld_mis   = w_misaligned;
          end
        end
      end

      ST_REQ: begin
        w_dm_req   = 1'b1;
        w_dm_we    = r_op_store;
        w_dm_addr  = {r_op_res[31:2], 2'b00};
        w_dm_wdata = r_op_b;
        if (dm_gnt) begin
          if (r_op_store) begin
            w_load_out  = 1'b1;
            w_ld_data   = r_op_res;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        if (dm_rvalid) begin
          w_load_out  = 1'b1;
          w_ld_data   = dm_rdata;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the memory operation on accept; held stable through REQ/RESP
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_op_rd    <= 5'd0;
      r_op_b     <= 32'd0;
      r_op_res   <= 32'd0;
      r_op_rf_en <= 1'b0;
      r_op_store <= 1'b0;
    end else if (w_latch_op) begin
      r_op_rd    <= ex_in.rd;
      r_op_b     <= ex_in.opr_b;
      r_op_res   <= ex_in.opr_res;
      r_op_rf_en <= ex_in.rf_en;
      r_op_store <= w_is_store;
    end
  end

  // Writeback output register: load a new beat, else clear on handshake
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_out_valid <= 1'b0;
      r_out_rd    <= 5'd0;
      r_out_data  <= 32'd0;
      r_out_rf_en <= 1'b0;
      r_out_mis   <= 1'b0;
    end else if (w_load_out) begin
      r_out_valid <= 1'b1;
      r_out_rd    <= w_ld_rd;
      r_out_data  <= w_ld_data;
      r_out_rf_en <= w_ld_rf_en;
      r_out_mis   <= w_ld_mis;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready       = w_in_ready;
  assign dm_req         = w_dm_req;
  assign dm_we          = w_dm_we;
  assign dm_addr        = w_dm_addr;
  assign dm_wdata       = w_dm_wdata;
  assign out_valid      = r_out_valid;
  assign out_rd         = r_out_rd;
  assign out_data       = r_out_data;
  assign out_rf_en      = r_out_rf_en;
  assign out_misaligned = r_out_mis;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed table-driven bench for mem_stage
module tb_mem_stage;
  import ex_stage_pkg::*;

  logic          clk;
  logic          arst_n;
  logic          in_valid;
  logic          in_ready;
  ex_stage_out_t ex_in;
  logic          dm_req;
  logic          dm_we;
  logic [31:0]   dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [31:0]   dm_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    out_rd;
  logic [31:0]   out_data;
  logic          out_rf_en;
  logic          out_misaligned;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ex_in          (ex_in),
    .dm_req         (dm_req),
    .dm_we          (dm_we),
    .dm_addr        (dm_addr),
    .dm_wdata       (dm_wdata),
    .dm_gnt         (dm_gnt),
    .dm_rvalid      (dm_rvalid),
    .dm_rdata       (dm_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rd         (out_rd),
    .out_data       (out_data),
    .out_rf_en      (out_rf_en),
    .out_misaligned (out_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        rf_en;
    logic [1:0]  wb_sel;
    logic [31:0] exp_data;
    logic        exp_rf_en;
  } alu_vec_t;

  alu_vec_t vecs[4];

  function automatic ex_stage_out_t mk(input logic [4:0] rd, input logic [31:0] b,
                                       input logic [31:0] res, input logic rf_en,
                                       input logic dm_en, input logic [1:0] wb_sel);
    ex_stage_out_t e;
    e.rd      = rd;
    e.opr_b   = b;
    e.opr_res = res;
    e.rf_en   = rf_en;
    e.dm_en   = dm_en;
    e.wb_sel  = wb_sel;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{rd: 5'd1, res: 32'h10, rf_en: 1'b1, wb_sel: 2'b00, exp_data: 32'h10, exp_rf_en: 1'b1};
    vecs[1] = '{rd: 5'd2, res: 32'h20, rf_en: 1'b1, wb_sel: 2'b00, exp_data: 32'h20, exp_rf_en: 1'b1};
    vecs[2] = '{rd: 5'd3, res: 32'h30, rf_en: 1'b1, wb_sel: 2'b00, exp_data: 32'h30, exp_rf_en: 1'b1};
    vecs[3] = '{rd: 5'd9, res: 32'h123, rf_en: 1'b0, wb_sel: 2'b10, exp_data: 32'h123, exp_rf_en: 1'b0};

    arst_n    = 1'b0;
    in_valid  = 1'b0;
    ex_in     = '0;
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    dm_rdata  = 32'd0;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dm_req",    32'(dm_req),    32'd0);
    chk("rst_dm_addr",   dm_addr,        32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    arst_n = 1'b1;
    tick();

    // Back-to-back ALU ops from the table
    for (int i = 0; i < 4; i++) begin
      ex_in    = mk(vecs[i].rd, 32'hFFFF_0000, vecs[i].res, vecs[i].rf_en, 1'b0, vecs[i].wb_sel);
      in_valid = 1'b1;
      #1;
      chk($sformatf("alu%0d_in_ready", i), 32'(in_ready), 32'd1);
      tick();
      chk($sformatf("alu%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("alu%0d_rd", i),    32'(out_rd),    32'(vecs[i].rd));
      chk($sformatf("alu%0d_data", i),  out_data,       vecs[i].exp_data);
      chk($sformatf("alu%0d_rf_en", i), 32'(out_rf_en), 32'(vecs[i].exp_rf_en));
      chk($sformatf("alu%0d_no_req", i), 32'(dm_req),   32'd0);
    end
    in_valid = 1'b0;
    tick();
    chk("alu_drain_valid", 32'(out_valid), 32'd0);

    // Store with grant delayed two cycles
    ex_in    = mk(5'd7, 32'hDEAD_BEEF, 32'h100, 1'b1, 1'b1, 2'b01);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ex_in    = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("st_req%0d", k),   32'(dm_req),   32'd1);
      chk($sformatf("st_we%0d", k),    32'(dm_we),    32'd1);
      chk($sformatf("st_addr%0d", k),  dm_addr,       32'h100);
      chk($sformatf("st_wdata%0d", k), dm_wdata,      32'hDEAD_BEEF);
      chk($sformatf("st_in_ready%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("st_out_valid%0d", k), 32'(out_valid), 32'd0);
      if (k == 2) dm_gnt = 1'b1;
      tick();
    end
    dm_gnt = 1'b0;
    chk("st_beat_valid", 32'(out_valid), 32'd1);
    chk("st_beat_data",  out_data,       32'h100);
    chk("st_beat_rf_en", 32'(out_rf_en), 32'd1);
    chk("st_beat_rd",    32'(out_rd),    32'd7);
    chk("st_req_off",    32'(dm_req),    32'd0);
    tick();
    chk("st_beat_clear", 32'(out_valid), 32'd0);

    // Load from 0x200, rvalid three cycles after grant
    ex_in    = mk(5'd5, 32'h0, 32'h200, 1'b1, 1'b0, 2'b01);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    dm_gnt   = 1'b1;
    #1;
    chk("ld_req",  32'(dm_req), 32'd1);
    chk("ld_we",   32'(dm_we),  32'd0);
    chk("ld_addr", dm_addr,     32'h200);
    tick();
    dm_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("ld_wait_in_ready%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("ld_wait_req%0d", k),      32'(dm_req),   32'd0);
      chk($sformatf("ld_wait_valid%0d", k),    32'(out_valid), 32'd0);
      if (k == 2) begin
        dm_rvalid = 1'b1;
        dm_rdata  = 32'hCAFE_F00D;
      end
      tick();
    end
    dm_rvalid = 1'b0;
    dm_rdata  = 32'd0;
    chk("ld_beat_valid", 32'(out_valid), 32'd1);
    chk("ld_beat_data",  out_data,       32'hCAFE_F00D);
    chk("ld_beat_rd",    32'(out_rd),    32'd5);
    chk("ld_beat_rf_en", 32'(out_rf_en), 32'd1);
    chk("ld_idle_ready", 32'(in_ready),  32'd1);
    tick();

    // Back-pressure: ALU beat held while a load waits
    out_ready = 1'b0;
    ex_in     = mk(5'd9, 32'h0, 32'h55, 1'b1, 1'b0, 2'b00);
    in_valid  = 1'b1;
    tick();
    ex_in = mk(5'd4, 32'h0, 32'h300, 1'b1, 1'b0, 2'b01);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("bp_in_ready%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp_valid%0d", k),    32'(out_valid), 32'd1);
      chk($sformatf("bp_data%0d", k),     out_data,       32'h55);
      chk($sformatf("bp_rd%0d", k),       32'(out_rd),    32'd9);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_ld_req",   32'(dm_req),   32'd1);
    chk("bp_ld_addr",  dm_addr,       32'h300);
    chk("bp_old_gone", 32'(out_valid), 32'd0);
    dm_gnt = 1'b1;
    tick();
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b1;
    dm_rdata  = 32'h0000_1234;
    tick();
    dm_rvalid = 1'b0;
    chk("bp_ld_valid", 32'(out_valid), 32'd1);
    chk("bp_ld_data",  out_data,       32'h0000_1234);
    chk("bp_ld_rd",    32'(out_rd),    32'd4);
    tick();

    // Misaligned load at 0x203
    ex_in    = mk(5'd6, 32'h0, 32'h203, 1'b1, 1'b0, 2'b01);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    chk("mis_no_req", 32'(dm_req),         32'd0);
    chk("mis_valid",  32'(out_valid),      32'd1);
    chk("mis_flag",   32'(out_misaligned), 32'd1);
    chk("mis_rf_en",  32'(out_rf_en),      32'd0);
    chk("mis_data",   out_data,            32'h203);
    tick();
`else
    chk("mis_req",  32'(dm_req), 32'd1);
    chk("mis_addr", dm_addr,     32'h200);
    dm_gnt = 1'b1;
    tick();
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b1;
    dm_rdata  = 32'h0BAD_0203;
    tick();
    dm_rvalid = 1'b0;
    chk("mis_valid", 32'(out_valid),      32'd1);
    chk("mis_flag",  32'(out_misaligned), 32'd0);
    chk("mis_data",  out_data,            32'h0BAD_0203);
    tick();
`endif

    // Reset in RESP: outputs clear at once, a late rvalid yields no beat
    ex_in    = mk(5'd12, 32'h0, 32'h400, 1'b1, 1'b0, 2'b01);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    dm_gnt   = 1'b1;
    tick();
    dm_gnt = 1'b0;
    #2;
    arst_n = 1'b0;
    #1;
    chk("rr_req",      32'(dm_req),    32'd0);
    chk("rr_valid",    32'(out_valid), 32'd0);
    chk("rr_out_data", out_data,       32'd0);
    chk("rr_out_rd",   32'(out_rd),    32'd0);
    chk("rr_in_ready", 32'(in_ready),  32'd1);
    tick();
    arst_n    = 1'b1;
    dm_rvalid = 1'b1;
    dm_rdata  = 32'h0BAD_BAAD;
    tick();
    dm_rvalid = 1'b0;
    chk("rr_late_rvalid", 32'(out_valid), 32'd0);
    tick();

    // Reset in REQ: dm_req drops without waiting for a clock
    ex_in    = mk(5'd13, 32'h1111_2222, 32'h500, 1'b1, 1'b1, 2'b00);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rq_req_before", 32'(dm_req), 32'd1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("rq_req_after",   32'(dm_req),   32'd0);
    chk("rq_wdata_after", dm_wdata,      32'd0);
    tick();
    arst_n = 1'b1;
    tick();
    chk("rq_idle_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage placed directly downstream of the execute stage. It accepts one execute result per handshake and issues word stores or loads to a variable-latency data memory. It then presents a registered writeback beat (destination register, result data, write enable) to the writeback stage. Only one memory operation is in flight at a time; ALU-only results pass through with one cycle of latency.

## Interface
Parameters:
- none; data and address width is fixed at 32 bits, matching the execute stage.

Ports:
- `clk`  in  1  stage clock; all state updates on its rising edge
- `arst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  execute result valid
- `in_ready`  out  1  stage can accept `ex_in` this cycle
- `ex_in`  in  73  `ex_stage_pkg::ex_stage_out_t`: rd, opr_b (store data), opr_res (ALU result/address), rf_en, dm_en (store), wb_sel
- `dm_req`  out  1  memory request
- `dm_we`  out  1  1 = store, 0 = load
- `dm_addr`  out  32  word-aligned byte address
- `dm_wdata`  out  32  store data
- `dm_gnt`  in  1  request accepted this cycle
- `dm_rvalid`  in  1  load data valid
- `dm_rdata`  in  32  load data
- `out_valid`  out  1  writeback beat valid
- `out_ready`  in  1  writeback stage accepts beat
- `out_rd`  out  5  destination register
- `out_data`  out  32  writeback value
- `out_rf_en`  out  1  register-file write enable
- `out_misaligned`  out  1  beat is a suppressed misaligned access

## Operation
- Operation classes:
  - Store: `dm_en=1`.
  - Load: `dm_en=0` and `wb_sel=2'b01`.
  - ALU: everything else.
  - If `dm_en=1` and `wb_sel=01`, the op is a store and no read is issued.
- FSM states are IDLE, REQ and RESP.
- IDLE:
  - `in_ready = (!out_valid || out_ready)`.
  - On accept, `ex_in` is latched.
  - ALU op: load the output register with `out_data=opr_res` and stay in IDLE.
  - Store or load: go to REQ.
- REQ:
  - Drive `dm_req=1`, `dm_we=store`, `dm_addr={opr_res[31:2],2'b00}`, `dm_wdata=opr_b`.
  - Hold all request signals stable until `dm_gnt`.
  - On `dm_gnt` for a store: load the output register (`out_data=opr_res`, `out_rf_en`=latched rf_en) and go to IDLE.
  - On `dm_gnt` for a load: go to RESP.
- RESP: `dm_rvalid` is sampled only in this state. When it is high, load the output register with `out_data=dm_rdata` and go to IDLE.
- `in_ready=0` in REQ and RESP.
- Because accept requires an empty or draining output register, a completing memory op always finds the output register free.
- The output register holds `out_valid` and all payload stable until `out_ready`. A beat clears on `out_valid && out_ready` unless a new beat loads in the same cycle.
- `dm_req`, `dm_we`, `dm_addr` and `dm_wdata` are 0 outside REQ.

## Timing
- Reset (async assert, sync release):
  - State is IDLE.
  - `out_valid`, `out_rd`, `out_data`, `out_rf_en`, `out_misaligned` and all `dm_*` outputs are 0.
  - `in_ready=1`.
- ALU op accepted at cycle N → `out_valid` at N+1. Throughput is 1 per cycle while `out_ready=1`.
- Store accepted at N → `dm_req` at N+1. With `dm_gnt` at N+1, `out_valid` at N+2.
- Load accepted at N → `dm_req` at N+1, `dm_gnt` at N+1, `dm_rvalid` earliest at N+2, `out_valid` at N+3.
- Each cycle of `dm_gnt=0` in REQ, or `dm_rvalid=0` in RESP, adds one cycle.
- Back-pressure: `out_valid && !out_ready` forces `in_ready=0`, and the payload is held.
- `arst_n` assertion mid-operation:
  - `dm_req` and `out_valid` drop immediately.
  - The in-flight op is discarded.
  - A `dm_rvalid` arriving after reset is ignored (the FSM is in IDLE).

## Configuration
- `MEM_STAGE_MISALIGN_CHECK_EN` defined:
  - A load or store with `opr_res[1:0]!=0` issues no `dm_req` and stays in IDLE.
  - It produces a beat at N+1 with `out_misaligned=1`, `out_rf_en=0`, `out_data=opr_res`.
- `MEM_STAGE_MISALIGN_CHECK_EN` undefined:
  - Low address bits are ignored (the address is force-aligned).
  - `out_misaligned` is tied to 0.

## Test plan
- Three back-to-back ALU ops (rd=1,2,3; opr_res=0x10,0x20,0x30), `out_ready=1` → beats on consecutive cycles N+1..N+3 with matching rd/data and `in_ready` high throughout.
- Store with opr_res=0x100, opr_b=0xDEADBEEF, `dm_gnt` delayed 2 cycles → `dm_req`/`dm_addr`/`dm_wdata` held stable 3 cycles; `out_valid` the cycle after gnt with `out_rf_en`=input rf_en.
- Load from 0x200 with rd=5, `dm_rvalid` 3 cycles after gnt with rdata=0xCAFEF00D → `out_data=0xCAFEF00D`, `out_rd=5`, `out_rf_en=1`; `in_ready=0` until the FSM returns to IDLE.
- ALU beat held with `out_ready=0` for 4 cycles while a load is presented → payload stable, `in_ready=0`; the load is accepted in the cycle `out_ready` rises.
- Load with opr_res=0x203:
  - With macro: no `dm_req`, beat with `out_misaligned=1`, `out_rf_en=0`.
  - Without macro: `dm_addr=0x200`.
- `arst_n` pulsed low while in RESP → all outputs 0 immediately; a late `dm_rvalid` after release produces no beat.
